// File: rtl/phy_pkg.sv
// Shared PHY definitions used by the word-to-byte serializer and its skid buffer.
//   PHY_WORD_W          width of a registered PHY word
//   PHY_BYTE_W          width of one line-side symbol
//   PHY_BYTES_PER_WORD  symbols per word
//   PHY_IDLE_SYM        symbol driven on idle cycles when IDLE_SYM_EN is defined
//   phy_state_t         serializer states (ST_IDLE, ST_SEND)
package phy_pkg;

  localparam int unsigned PHY_WORD_W         = 32;
  localparam int unsigned PHY_BYTE_W         = 8;
  localparam int unsigned PHY_BYTES_PER_WORD = PHY_WORD_W / PHY_BYTE_W;
  localparam logic [7:0]  PHY_IDLE_SYM       = 8'hBC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } phy_state_t;

  // Width of a counter that must hold 0..n-1; never narrower than 1 bit.
  function automatic int unsigned phy_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/module_word_skid.sv
// One-entry skid buffer holding a single word.
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset (empties the buffer)
//   load      capture data_in, buffer becomes full
//   drain     release the held word, buffer becomes empty
//   data_in   word to capture
//   data_out  held word (valid while full)
//   full      1 = a word is held
module module_word_skid #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         full
);

  logic [W-1:0] word;
  logic         held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      held <= 1'b0;
    end else begin
      if (load) begin
        word <= data_in;
      end
      // Upstream only loads while empty, so load and drain never coincide.
      held <= load | (held & ~drain);
    end
  end

  assign data_out = word;
  assign full     = held;

endmodule

// File: rtl/module_word_to_byte.sv
// Word-to-byte serializer for the PHY line side.
// Converts registered DATA_W-bit words into BYTE_W-bit symbols, one per clk_4f
// cycle, most significant byte first. A one-word skid buffer absorbs a word
// arriving while the previous one is still being sent, so one word every N
// cycles yields a gap-free byte stream.
// Configuration macro: IDLE_SYM_EN -- when defined, data_out carries IDLE_SYM
// on cycles with valid_out = 0 (reset value stays 0); otherwise it carries 0.
// Ports:
//   clk_4f     byte clock, rising edge
//   reset_L    asynchronous active-low reset
//   valid_in   data_in holds a word; held high until accepted
//   data_in    input word
//   ready_out  1 = skid buffer empty, a word may be accepted
//   valid_out  data_out carries a valid byte this cycle
//   data_out   current byte (registered)
module module_word_to_byte
  import phy_pkg::*;
#(
  parameter int unsigned       DATA_W   = PHY_WORD_W,
  parameter int unsigned       BYTE_W   = PHY_BYTE_W,
  parameter logic [BYTE_W-1:0] IDLE_SYM = BYTE_W'(PHY_IDLE_SYM)
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [BYTE_W-1:0] data_out
);

  localparam int unsigned       N        = DATA_W / BYTE_W;
  localparam int unsigned       CNT_W    = phy_cnt_w(N);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

`ifdef IDLE_SYM_EN
  localparam logic [BYTE_W-1:0] IDLE_VAL = IDLE_SYM;
`else
  localparam logic [BYTE_W-1:0] IDLE_VAL = '0;
`endif

  generate
    if ((DATA_W % BYTE_W) != 0 || N == 0 || $bits(IDLE_SYM) != BYTE_W) begin : g_bad_cfg
      $error("DATA_W must be a non-zero integer multiple of BYTE_W");
    end
  endgenerate

  phy_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] shifter, shifter_nxt;
  logic [BYTE_W-1:0] data_q, data_nxt;
  logic              valid_q, valid_nxt;

  logic              accept;
  logic              skid_load;
  logic              skid_drain;
  logic              skid_full;
  logic [DATA_W-1:0] skid_data;

  assign ready_out = ~skid_full;
  assign accept    = valid_in & ready_out;

  module_word_skid #(
    .W (DATA_W)
  ) u_skid (
    .clk      (clk_4f),
    .rst_n    (reset_L),
    .load     (skid_load),
    .drain    (skid_drain),
    .data_in  (data_in),
    .data_out (skid_data),
    .full     (skid_full)
  );

  // The MSB byte of a freshly loaded word goes straight to data_out; the
  // shifter keeps the rest left-aligned so the next byte is always on top.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shifter_nxt = shifter;
    data_nxt    = data_q;
    valid_nxt   = valid_q;
    skid_load   = 1'b0;
    skid_drain  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt   = ST_SEND;
          cnt_nxt     = '0;
          data_nxt    = data_in[DATA_W-1 -: BYTE_W];
          shifter_nxt = data_in << BYTE_W;
          valid_nxt   = 1'b1;
        end else begin
          data_nxt  = IDLE_VAL;
          valid_nxt = 1'b0;
        end
      end

      ST_SEND: begin
        if (cnt == CNT_LAST) begin
          if (skid_full) begin
            skid_drain  = 1'b1;
            cnt_nxt     = '0;
            data_nxt    = skid_data[DATA_W-1 -: BYTE_W];
            shifter_nxt = skid_data << BYTE_W;
            valid_nxt   = 1'b1;
          end else if (accept) begin
            cnt_nxt     = '0;
            data_nxt    = data_in[DATA_W-1 -: BYTE_W];
            shifter_nxt = data_in << BYTE_W;
            valid_nxt   = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            data_nxt  = IDLE_VAL;
            valid_nxt = 1'b0;
          end
        end else begin
          cnt_nxt     = cnt + 1'b1;
          data_nxt    = shifter[DATA_W-1 -: BYTE_W];
          shifter_nxt = shifter << BYTE_W;
          valid_nxt   = 1'b1;
          // accept implies the skid is empty, so this never overwrites a word.
          skid_load   = accept;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      shifter <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shifter <= shifter_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_module_word_to_byte.sv
module tb_module_word_to_byte;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_out;
  logic        valid_out;
  logic [7:0]  data_out;

  int checks   = 0;
  int failures = 0;

`ifdef IDLE_SYM_EN
  localparam logic [7:0] IDLE_VAL = 8'hBC;
`else
  localparam logic [7:0] IDLE_VAL = 8'h00;
`endif

  module_word_to_byte #(
    .DATA_W   (32),
    .BYTE_W   (8),
    .IDLE_SYM (8'hBC)
  ) dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk_4f = ~clk_4f;

  // Reference model: a FIFO of bytes not yet shown on data_out. An accepted
  // word appends its four bytes MSB first; every edge shows the head byte.
  // One word may wait behind the one being sent, so more than three pending
  // bytes means the buffer is occupied and upstream must wait.
  logic [7:0] pend[$];
  logic       exp_valid;
  logic [7:0] exp_data;
  logic       exp_ready;

  task automatic model_reset();
    pend.delete();
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    exp_ready = 1'b1;
  endtask

  // Drive one cycle of input, advance through the rising edge, update model.
  task automatic cycle(input logic vin, input logic [31:0] din, output logic acc);
    valid_in = vin;
    data_in  = din;
    acc      = vin && exp_ready;
    @(posedge clk_4f);
    #1;
    if (acc) begin
      for (int i = 3; i >= 0; i--) pend.push_back(din[i*8 +: 8]);
    end
    if (pend.size() > 0) begin
      exp_valid = 1'b1;
      exp_data  = pend.pop_front();
    end else begin
      exp_valid = 1'b0;
      exp_data  = IDLE_VAL;
    end
    exp_ready = (pend.size() < 4);
  endtask

  task automatic test_reset();
    logic acc;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_4f);
      #1;
      checks++;
      if (valid_out !== 1'b0 || data_out !== 8'h00 || ready_out !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold cyc %0d: got v=%b d=%h r=%b, expected v=0 d=00 r=1",
                 c, valid_out, data_out, ready_out);
      end
    end
    #2 reset_L = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got v=%b d=%h r=%b, expected v=0 d=00 r=1",
               valid_out, data_out, ready_out);
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 32'h0, acc);
      checks++;
      if (valid_out !== exp_valid || data_out !== exp_data || ready_out !== exp_ready) begin
        failures++;
        $display("FAIL reset_idle cyc %0d: got v=%b d=%h r=%b, expected v=%b d=%h r=%b",
                 c, valid_out, data_out, ready_out, exp_valid, exp_data, exp_ready);
      end
    end
  endtask

  task automatic test_single_word();
    logic       acc;
    logic [7:0] want [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] got[$];
    for (int c = 0; c < 8; c++) begin
      cycle(c == 0, (c == 0) ? 32'hDEADBEEF : 32'h0, acc);
      if (valid_out === 1'b1) got.push_back(data_out);
      checks++;
      if (valid_out !== exp_valid || data_out !== exp_data || ready_out !== exp_ready) begin
        failures++;
        $display("FAIL single_word cyc %0d: got v=%b d=%h r=%b, expected v=%b d=%h r=%b",
                 c, valid_out, data_out, ready_out, exp_valid, exp_data, exp_ready);
      end
    end
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL single_word_count: got %0d bytes, expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== want[i]) begin
          failures++;
          $display("FAIL single_word_byte%0d: got %h, expected %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   run = 0;
    int   best = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      cycle(1'b1, 32'h01020304, acc);
      else if (c == 4) cycle(1'b1, 32'hA0B0C0D0, acc);
      else             cycle(1'b0, 32'h0, acc);
      run  = (valid_out === 1'b1) ? run + 1 : 0;
      best = (run > best) ? run : best;
      checks++;
      if (valid_out !== exp_valid || data_out !== exp_data || ready_out !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back cyc %0d: got v=%b d=%h r=%b, expected v=%b d=%h r=1",
                 c, valid_out, data_out, ready_out, exp_valid, exp_data);
      end
    end
    checks++;
    if (best != 8) begin
      failures++;
      $display("FAIL back_to_back_run: got %0d contiguous bytes, expected 8", best);
    end
  endtask

  task automatic test_skid();
    logic        acc;
    logic        c_done = 1'b0;
    logic [7:0]  got[$];
    logic [31:0] words [3] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    logic [31:0] w;
    for (int c = 0; c < 24; c++) begin
      if (c == 0)                 cycle(1'b1, words[0], acc);
      else if (c == 2)            cycle(1'b1, words[1], acc);
      else if (c >= 3 && !c_done) begin
        cycle(1'b1, words[2], acc);
        c_done = acc;
      end else                    cycle(1'b0, 32'h0, acc);
      if (valid_out === 1'b1) got.push_back(data_out);
      checks++;
      if (valid_out !== exp_valid || data_out !== exp_data || ready_out !== exp_ready) begin
        failures++;
        $display("FAIL skid cyc %0d: got v=%b d=%h r=%b, expected v=%b d=%h r=%b",
                 c, valid_out, data_out, ready_out, exp_valid, exp_data, exp_ready);
      end
    end
    checks++;
    if (!c_done) begin
      failures++;
      $display("FAIL skid_c_accept: got not accepted within budget, expected accepted");
    end
    checks++;
    if (got.size() != 12) begin
      failures++;
      $display("FAIL skid_count: got %0d bytes, expected 12", got.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        w = words[i/4];
        checks++;
        if (got[i] !== w[(3 - i%4)*8 +: 8]) begin
          failures++;
          $display("FAIL skid_order byte%0d: got %h, expected %h", i, got[i], w[(3 - i%4)*8 +: 8]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    cycle(1'b1, 32'h11112222, acc);
    cycle(1'b0, 32'h0, acc);
    cycle(1'b1, 32'h33334444, acc);
    checks++;
    if (ready_out !== 1'b0 || exp_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_setup: got r=%b, expected r=0 (skid full)", ready_out);
    end
    #2 reset_L = 1'b0;
    #1;
    model_reset();
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got v=%b d=%h r=%b, expected v=0 d=00 r=1",
               valid_out, data_out, ready_out);
    end
    #2 reset_L = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle(c == 1, (c == 1) ? 32'h5A6B7C8D : 32'h0, acc);
      checks++;
      if (valid_out !== exp_valid || data_out !== exp_data || ready_out !== exp_ready) begin
        failures++;
        $display("FAIL async_recover cyc %0d: got v=%b d=%h r=%b, expected v=%b d=%h r=%b",
                 c, valid_out, data_out, ready_out, exp_valid, exp_data, exp_ready);
      end
    end
  endtask

  task automatic test_random();
    logic        acc;
    logic        holding = 1'b0;
    logic [31:0] word = '0;
    int unsigned dens;
    for (int c = 0; c < 600; c++) begin
      dens = (c < 200) ? 1 : ((c < 400) ? 3 : 8);
      if (!holding && $urandom_range(0, 9) < dens) begin
        holding = 1'b1;
        word    = $urandom;
      end
      cycle(holding, holding ? word : 32'h0, acc);
      if (acc) holding = 1'b0;
      checks++;
      if (valid_out !== exp_valid || data_out !== exp_data || ready_out !== exp_ready) begin
        failures++;
        $display("FAIL random cyc %0d: got v=%b d=%h r=%b, expected v=%b d=%h r=%b",
                 c, valid_out, data_out, ready_out, exp_valid, exp_data, exp_ready);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_skid();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
